board_lock_clear: RTL and testbench

Writer side of the playfield memory that the ghost-piece logic reads. When the falling piece locks, the block commits its four cells into the 200-bit board. It then scans and removes full rows, collapsing the rows above them. It reports how many lines were cleared for scoring and publishes the updated board to the renderer, controller and ghost-piece logic.

---
 rtl/board_lock_clear_pkg.sv | 26 ++
 rtl/board_lock_clear_row_full_detect.sv | 17 +
 rtl/board_lock_clear.sv | 116 +++++++++++
 tb/tb_board_lock_clear.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_lock_clear_pkg.sv
// rtl/board_lock_clear_pkg.sv - shared playfield geometry, FSM encodings and cell indexing
package board_lock_clear_pkg;

  localparam int WIDTH  = 10;
  localparam int HEIGHT = 20;
  localparam int CELLS  = WIDTH * HEIGHT;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [4:0] LAST_ROW  = 5'(HEIGHT - 1);
  localparam logic [2:0] MAX_LINES = 3'd4;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } cell_t;

  // Same y*WIDTH+x mapping the ghost-piece reader uses; only valid for in-range cells.
  function automatic logic [7:0] cell_index(input logic [4:0] y, input logic [3:0] x);
    return 8'(y) * 8'(WIDTH) + 8'(x);
  endfunction

endpackage

// File: rtl/board_lock_clear_row_full_detect.sv
// rtl/board_lock_clear_row_full_detect.sv - flags whether the selected board row is completely filled
module board_lock_clear_row_full_detect
  import board_lock_clear_pkg::*;
(
  input  logic [0:CELLS-1] board,
  input  logic [4:0]       row,
  output logic             full
);

  always_comb begin
    full = 1'b0;
    for (int r = 0; r < HEIGHT; r++) begin
      if (row == 5'(r)) full = &board[r*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/board_lock_clear.sv
// rtl/board_lock_clear.sv - commits a locked piece into the board, then removes and collapses full rows
module board_lock_clear
  import board_lock_clear_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             lock_req,
  input  logic             board_clr,
  input  logic [9:0]       X1,
  input  logic [9:0]       X2,
  input  logic [9:0]       X3,
  input  logic [9:0]       X4,
  input  logic [9:0]       Y1,
  input  logic [9:0]       Y2,
  input  logic [9:0]       Y3,
  input  logic [9:0]       Y4,
  output logic [0:CELLS-1] boardMemory,
  output logic             busy,
  output logic             done,
  output logic [2:0]       lines_cleared,
  output logic [15:0]      total_lines,
  output logic             game_over
);

  logic [1:0]       state;
  logic [4:0]       row;
  logic [2:0]       acc;
  cell_t            cells [4];
  logic [0:CELLS-1] cell_mask;
  logic [0:CELLS-1] shifted;
  logic             collide;
  logic             top_out;
  logic             row_full;
  logic [16:0]      total_sum;

  board_lock_clear_row_full_detect u_row_full_detect (
    .board (boardMemory),
    .row   (row),
    .full  (row_full)
  );

  // Out-of-range cells are simply absent from the mask; a Y=0 cell tops out regardless of X.
  always_comb begin
    cell_mask = '0;
    top_out   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cells[i].x < 10'(WIDTH) && cells[i].y < 10'(HEIGHT))
        cell_mask[cell_index(cells[i].y[4:0], cells[i].x[3:0])] = 1'b1;
      if (cells[i].y == 10'd0) top_out = 1'b1;
    end
    collide = |(boardMemory & cell_mask);
  end

  // Rows 1..row drop by one and row 0 empties; rows below the pointer are untouched.
  always_comb begin
    shifted = boardMemory;
    for (int k = 1; k < HEIGHT; k++) begin
      if (5'(k) <= row) shifted[k*WIDTH +: WIDTH] = boardMemory[(k-1)*WIDTH +: WIDTH];
    end
    shifted[0 +: WIDTH] = '0;
  end

  assign total_sum = {1'b0, total_lines} + {14'd0, acc};
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      row           <= LAST_ROW;
      acc           <= '0;
      boardMemory   <= '0;
      lines_cleared <= '0;
      total_lines   <= '0;
      game_over     <= 1'b0;
      for (int i = 0; i < 4; i++) cells[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (board_clr) begin
            boardMemory <= '0;
            total_lines <= '0;
            game_over   <= 1'b0;
          end else if (lock_req && !game_over) begin
            cells[0] <= '{x: X1, y: Y1};
            cells[1] <= '{x: X2, y: Y2};
            cells[2] <= '{x: X3, y: Y3};
            cells[3] <= '{x: X4, y: Y4};
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          boardMemory <= boardMemory | cell_mask;
          if (collide || top_out) game_over <= 1'b1;
          acc   <= '0;
          row   <= LAST_ROW;
          state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (row_full) begin
            boardMemory <= shifted;
            if (acc != MAX_LINES) acc <= acc + 3'd1;
          end else if (row == 5'd0) begin
            lines_cleared <= acc;
            total_lines   <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
            state         <= ST_DONE;
          end else begin
            row <= row - 5'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_lock_clear.sv
// tb/tb_board_lock_clear.sv - vector table plus scoreboard bench for board_lock_clear
module tb_board_lock_clear;

  logic         clk = 1'b0;
  logic         rst;
  logic         lock_req;
  logic         board_clr;
  logic [9:0]   xi [4];
  logic [9:0]   yi [4];
  logic [0:199] board_q;
  logic         busy;
  logic         done;
  logic [2:0]   lines_cleared;
  logic [15:0]  total_lines;
  logic         game_over;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic            clr;
    logic [3:0][9:0] xs;
    logic [3:0][9:0] ys;
    int              lines;
    int              lat;
  } vec_t;

  typedef struct {
    int           lines;
    int           lat;
    int           total;
    logic [199:0] board;
    logic         go;
  } exp_t;

  vec_t vecs [$];
  exp_t sb   [$];

  logic [0:199] mb;
  int           mtotal;
  logic         mgo;

  board_lock_clear dut (
    .clk           (clk),
    .rst           (rst),
    .lock_req      (lock_req),
    .board_clr     (board_clr),
    .X1            (xi[0]),
    .X2            (xi[1]),
    .X3            (xi[2]),
    .X4            (xi[3]),
    .Y1            (yi[0]),
    .Y2            (yi[1]),
    .Y3            (yi[2]),
    .Y4            (yi[3]),
    .boardMemory   (board_q),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .total_lines   (total_lines),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic c, input int x0, input int x1, input int x2, input int x3,
                              input int y0, input int y1, input int y2, input int y3,
                              input int l, input int t);
    vec_t v;
    v.clr = c;
    v.xs[0] = 10'(x0); v.xs[1] = 10'(x1); v.xs[2] = 10'(x2); v.xs[3] = 10'(x3);
    v.ys[0] = 10'(y0); v.ys[1] = 10'(y1); v.ys[2] = 10'(y2); v.ys[3] = 10'(y3);
    v.lines = l;
    v.lat = t;
    return v;
  endfunction

  // Reference: commit the piece, then compact surviving rows toward the bottom.
  task automatic model_lock(input logic [3:0][9:0] xs, input logic [3:0][9:0] ys);
    logic [0:199] nb;
    logic         coll;
    logic         full;
    int           w;
    coll = 1'b0;
    for (int i = 0; i < 4; i++)
      if (xs[i] < 10 && ys[i] < 20 && mb[int'(ys[i]) * 10 + int'(xs[i])]) coll = 1'b1;
    for (int i = 0; i < 4; i++)
      if (xs[i] < 10 && ys[i] < 20) mb[int'(ys[i]) * 10 + int'(xs[i])] = 1'b1;
    for (int i = 0; i < 4; i++)
      if (ys[i] == 0) coll = 1'b1;
    if (coll) mgo = 1'b1;
    nb = '0;
    w = 19;
    for (int r = 19; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < 10; c++) if (!mb[r*10 + c]) full = 1'b0;
      if (full) mtotal++;
      else begin
        for (int c = 0; c < 10; c++) nb[w*10 + c] = mb[r*10 + c];
        w--;
      end
    end
    if (mtotal > 65535) mtotal = 65535;
    mb = nb;
  endtask

  task automatic do_clear();
    @(negedge clk);
    board_clr = 1'b1;
    @(negedge clk);
    board_clr = 1'b0;
    mb = '0;
    mtotal = 0;
    mgo = 1'b0;
    chk("clr_board", board_q, 200'd0);
    chk("clr_game_over", game_over, 1'b0);
    chk("clr_total", total_lines, 0);
  endtask

  task automatic watch(input int ncyc, output int nbusy, output int ndone);
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) ndone++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int intrude);
    exp_t e;
    int   n;
    if (v.clr) do_clear();
    model_lock(v.xs, v.ys);
    e.lines = v.lines;
    e.lat   = v.lat;
    e.total = mtotal;
    e.board = mb;
    e.go    = mgo;
    sb.push_back(e);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      xi[i] = v.xs[i];
      yi[i] = v.ys[i];
    end
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    chk("busy_rise", busy, 1'b1);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      lock_req = (intrude != 0 && n == intrude);
      if (lock_req) begin
        for (int i = 0; i < 4; i++) begin
          xi[i] = 10'd7;
          yi[i] = 10'(5 + i);
        end
      end
    end
    lock_req = 1'b0;
    e = sb.pop_front();
    chk("done_seen", done, 1'b1);
    chk("latency", n, e.lat);
    chk("lines_cleared", lines_cleared, e.lines);
    chk("total_lines", total_lines, e.total);
    chk("board", board_q, e.board);
    chk("game_over", game_over, e.go);
    @(negedge clk);
    chk("done_pulse_end", done, 1'b0);
    chk("busy_fall", busy, 1'b0);
  endtask

  initial begin
    int nbusy;
    int ndone;
    vec_t v;

    rst = 1'b1;
    lock_req = 1'b0;
    board_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xi[i] = '0;
      yi[i] = '0;
    end
    mb = '0;
    mtotal = 0;
    mgo = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_board", board_q, 200'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_lines", lines_cleared, 0);
    chk("rst_total", total_lines, 0);
    chk("rst_game_over", game_over, 1'b0);
    rst = 1'b0;

    vecs.push_back(mk(1, 3, 4, 5, 6, 19, 19, 19, 19, 0, 21));
    vecs.push_back(mk(1, 1, 2, 3, 4, 19, 19, 19, 19, 0, 21));
    vecs.push_back(mk(0, 5, 6, 7, 8, 19, 19, 19, 19, 0, 21));
    vecs.push_back(mk(0, 9, 2, 0, 0, 19, 18, 25, 25, 0, 21));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16, 17, 18, 19, 1, 22));
    vecs.push_back(mk(0, 12, 3, 7, 0, 5, 30, 20, 21, 0, 21));
    for (int r = 16; r < 20; r++) begin
      vecs.push_back(mk(r == 16, 0, 1, 2, 3, r, r, r, r, 0, 21));
      vecs.push_back(mk(0, 4, 5, 6, 7, r, r, r, r, 0, 21));
      vecs.push_back(mk(0, 8, 0, 0, 0, r, 25, 25, 25, 0, 21));
    end
    vecs.push_back(mk(0, 9, 9, 9, 9, 16, 17, 18, 19, 4, 25));

    foreach (vecs[i]) run_vec(vecs[i], 0);

    // Reset in the middle of a scan, with nonzero totals and line count held.
    @(negedge clk);
    xi[0] = 10'd1; xi[1] = 10'd2; xi[2] = 10'd3; xi[3] = 10'd4;
    for (int i = 0; i < 4; i++) yi[i] = 10'd19;
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_board", board_q, 200'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_lines", lines_cleared, 0);
    chk("midrst_total", total_lines, 0);
    chk("midrst_game_over", game_over, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mb = '0;
    mtotal = 0;
    mgo = 1'b0;

    // Collision onto an occupied cell, then a lock that must be ignored.
    run_vec(mk(1, 2, 0, 0, 0, 10, 25, 25, 25, 0, 21), 0);
    run_vec(mk(0, 2, 3, 4, 5, 10, 10, 10, 10, 0, 21), 0);
    @(negedge clk);
    xi[0] = 10'd6; yi[0] = 10'd15;
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    watch(40, nbusy, ndone);
    chk("go_lock_busy", nbusy, 0);
    chk("go_lock_done", ndone, 0);
    chk("go_lock_board", board_q, mb);
    do_clear();

    // Top-out on a Y=0 cell.
    run_vec(mk(0, 5, 5, 5, 5, 0, 1, 2, 3, 0, 21), 0);
    do_clear();

    // A lock request during SCAN is dropped; only one completion follows.
    run_vec(mk(1, 0, 1, 2, 3, 19, 19, 19, 19, 0, 21), 5);
    watch(30, nbusy, ndone);
    chk("intrude_busy", nbusy, 0);
    chk("intrude_done", ndone, 0);

    // Simultaneous clear and lock in IDLE: clear wins.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      xi[i] = 10'(i);
      yi[i] = 10'd12;
    end
    lock_req = 1'b1;
    board_clr = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    board_clr = 1'b0;
    mb = '0;
    mtotal = 0;
    chk("both_board", board_q, 200'd0);
    chk("both_busy", busy, 1'b0);
    watch(30, nbusy, ndone);
    chk("both_busy_window", nbusy, 0);
    chk("both_done_window", ndone, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
